// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issue/handshake controller between the execute stage and the
// iterative divider / multiplier engines, with request screening and a run watchdog.
module multdiv_sequencer #(
  parameter int MAX_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] div_A,
  output logic [31:0] div_B,
  output logic        div_start,
  input  logic [31:0] div_out,
  input  logic        div_exp,
  input  logic        div_ready,
  output logic [31:0] mult_A,
  output logic [31:0] mult_B,
  output logic        mult_start,
  input  logic [31:0] mult_out,
  input  logic        mult_exp,
  input  logic        mult_ready
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIV_RUN = 2'd1;
  localparam logic [1:0] S_MUL_RUN = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [5:0] CNT_LAST = 6'(MAX_CYCLES - 1);

  logic [1:0]  state_q,  state_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [31:0] opa_q,    opa_d;
  logic [31:0] opb_q,    opb_d;
  logic [31:0] result_q, result_d;
  logic        exc_q,    exc_d;
  logic        rdy_q,    rdy_d;
  logic        busy_q,   busy_d;

  // Divisor of zero cannot be handed to the divider.
  function automatic logic is_div_by_zero(input logic [31:0] b);
    return (b == 32'h0000_0000);
  endfunction

  // The single signed quotient that does not fit in 32 bits: INT_MIN / -1.
  function automatic logic is_div_overflow(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Next-state, operand latch and result capture decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_DIV && ctrl_MULT) begin
          state_d  = S_DONE;
          result_d = 32'h0000_0000;
          exc_d    = 1'b1;
        end else if (ctrl_DIV && is_div_by_zero(data_operandB)) begin
          state_d  = S_DONE;
          result_d = 32'h0000_0000;
          exc_d    = 1'b1;
        end else if (ctrl_DIV && is_div_overflow(data_operandA, data_operandB)) begin
          state_d  = S_DONE;
          result_d = 32'h8000_0000;
          exc_d    = 1'b1;
        end else if (ctrl_DIV) begin
          state_d = S_DIV_RUN;
          cnt_d   = 6'd0;
          opa_d   = data_operandA;
          opb_d   = data_operandB;
        end else if (ctrl_MULT) begin
          state_d = S_MUL_RUN;
          cnt_d   = 6'd0;
          opa_d   = data_operandA;
          opb_d   = data_operandB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (div_ready) begin
          state_d  = S_DONE;
          result_d = div_out;
          exc_d    = div_exp;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = 32'h0000_0000;
          exc_d    = 1'b1;
        end else begin
          state_d = S_DIV_RUN;
        end
      end
      S_MUL_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (mult_ready) begin
          state_d  = S_DONE;
          result_d = mult_out;
          exc_d    = mult_exp;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = 32'h0000_0000;
          exc_d    = 1'b1;
        end else begin
          state_d = S_MUL_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rdy_d  = (state_d == S_DONE);
    busy_d = (state_d == S_DIV_RUN) || (state_d == S_MUL_RUN);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      opa_q    <= 32'h0000_0000;
      opb_q    <= 32'h0000_0000;
      result_q <= 32'h0000_0000;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  // Start pulses only in the first run cycle; both engines share the operand latch.
  assign div_start  = (state_q == S_DIV_RUN) && (cnt_q == 6'd0);
  assign mult_start = (state_q == S_MUL_RUN) && (cnt_q == 6'd0);
  assign div_A      = opa_q;
  assign div_B      = opb_q;
  assign mult_A     = opa_q;
  assign mult_B     = opb_q;

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

  multdiv_sequencer_checker u_checker (
    .clock          (clock),
    .reset          (reset),
    .div_start      (div_start),
    .mult_start     (mult_start),
    .busy           (busy),
    .data_resultRDY (data_resultRDY)
  );

endmodule

// multdiv_sequencer_checker: handshake invariants of the sequencer outputs.
module multdiv_sequencer_checker (
  input logic clock,
  input logic reset,
  input logic div_start,
  input logic mult_start,
  input logic busy,
  input logic data_resultRDY
);

  a_one_start: assert property (@(posedge clock) disable iff (reset)
    !(div_start && mult_start));

  a_rdy_not_busy: assert property (@(posedge clock) disable iff (reset)
    !(data_resultRDY && busy));

  a_div_start_busy: assert property (@(posedge clock) disable iff (reset)
    div_start |-> busy);

  a_mult_start_busy: assert property (@(posedge clock) disable iff (reset)
    mult_start |-> busy);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: model engines plus a transaction-level
// reference that predicts completion cycle, result and exception of every request.
module tb_multdiv_sequencer;

  localparam int MAXC = 40;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [31:0] div_A;
  logic [31:0] div_B;
  logic        div_start;
  logic [31:0] div_out;
  logic        div_exp;
  logic        div_ready;
  logic [31:0] mult_A;
  logic [31:0] mult_B;
  logic        mult_start;
  logic [31:0] mult_out;
  logic        mult_exp;
  logic        mult_ready;

  multdiv_sequencer #(.MAX_CYCLES(MAXC)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .div_A          (div_A),
    .div_B          (div_B),
    .div_start      (div_start),
    .div_out        (div_out),
    .div_exp        (div_exp),
    .div_ready      (div_ready),
    .mult_A         (mult_A),
    .mult_B         (mult_B),
    .mult_start     (mult_start),
    .mult_out       (mult_out),
    .mult_exp       (mult_exp),
    .mult_ready     (mult_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int eng_lat = 0;
  bit eng_exc = 1'b0;
  int spur_div_at = -1;
  int spur_mult_at = -1;
  bit div_pend = 1'b0;
  bit mult_pend = 1'b0;
  int div_left = 0;
  int mult_left = 0;
  logic [31:0] div_res = 32'd0;
  logic [31:0] mult_res = 32'd0;
  logic [31:0] last_r = 32'd0;
  bit last_x = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Engine models: ready eng_lat cycles after the start cycle; eng_lat >= MAXC never readies.
  always @(negedge clock) begin
    div_ready  = 1'b0;
    mult_ready = 1'b0;
    if (reset) begin
      div_pend  = 1'b0;
      mult_pend = 1'b0;
    end else begin
      if (div_start && eng_lat < MAXC) begin
        div_pend = 1'b1;
        div_left = eng_lat;
        div_res  = (div_B == 32'd0) ? 32'd0 : $signed(div_A) / $signed(div_B);
      end
      if (mult_start && eng_lat < MAXC) begin
        mult_pend = 1'b1;
        mult_left = eng_lat;
        mult_res  = mult_A * mult_B;
      end
      if (div_pend) begin
        if (div_left == 0) begin
          div_ready = 1'b1; div_out = div_res; div_exp = eng_exc; div_pend = 1'b0;
        end else div_left--;
      end
      if (mult_pend) begin
        if (mult_left == 0) begin
          mult_ready = 1'b1; mult_out = mult_res; mult_exp = eng_exc; mult_pend = 1'b0;
        end else mult_left--;
      end
      if (cyc == spur_div_at) begin
        div_ready = 1'b1; div_out = 32'hDEAD_BEEF; div_exp = 1'b1;
      end
      if (cyc == spur_mult_at) begin
        mult_ready = 1'b1; mult_out = 32'hBAD0_CAFE; mult_exp = 1'b1;
      end
    end
  end

  // Reference: outcome of one request. eng 0 = screened, 1 = divider, 2 = multiplier;
  // rdy_at = cycles from the request cycle to the completion pulse.
  task automatic predict(input bit d, input bit m, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit eexc, output logic [31:0] r, output bit x,
                         output int eng, output int rdy_at);
    eng = 0; rdy_at = 1; r = 32'd0; x = 1'b1;
    if (d && m) r = 32'd0;
    else if (d && b == 32'd0) r = 32'd0;
    else if (d && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
    else begin
      eng = d ? 1 : 2;
      if (lat <= MAXC - 1) begin
        rdy_at = lat + 2;
        x = eexc;
        r = d ? $signed(a) / $signed(b) : a * b;
      end else rdy_at = MAXC + 1;
    end
  endtask

  // Called at a negedge of an IDLE or DONE cycle; returns at the negedge of the DONE cycle.
  task automatic run_op(input bit d, input bit m, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit eexc, input int spur_k, input int drop_at);
    logic [31:0] r;
    bit x;
    int eng, rdy_at, nds, nms, nbusy, early;
    logic [31:0] sa_d, sb_d, sa_m, sb_m;
    predict(d, m, a, b, lat, eexc, r, x, eng, rdy_at);
    eng_lat = lat; eng_exc = eexc;
    if (spur_k >= 1 && spur_k < rdy_at) begin
      if (eng == 1) spur_mult_at = cyc + spur_k;
      else spur_div_at = cyc + spur_k;
    end
    ctrl_DIV = d; ctrl_MULT = m; data_operandA = a; data_operandB = b;
    nds = 0; nms = 0; nbusy = 0; early = 0;
    sa_d = 32'd0; sb_d = 32'd0; sa_m = 32'd0; sb_m = 32'd0;
    for (int k = 1; k <= rdy_at; k++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0; ctrl_MULT = 1'b0;
      data_operandA = $urandom; data_operandB = $urandom;
      if (div_start) nds++;
      if (mult_start) nms++;
      if (busy) nbusy++;
      if (k < rdy_at && data_resultRDY) early++;
      if (k == 1) begin sa_d = div_A; sb_d = div_B; sa_m = mult_A; sb_m = mult_B; end
      if (k == drop_at && k < rdy_at) begin ctrl_DIV = 1'b1; data_operandB = 32'd0; end
    end
    check_eq("rdy_early", early, 32'd0);
    check_eq("rdy", 32'(data_resultRDY), 32'd1);
    check_eq("result", data_result, r);
    check_eq("exc", 32'(data_exception), 32'(x));
    check_eq("div_starts", nds, (eng == 1) ? 32'd1 : 32'd0);
    check_eq("mult_starts", nms, (eng == 2) ? 32'd1 : 32'd0);
    check_eq("busy_cycles", nbusy, (eng != 0) ? 32'(rdy_at - 1) : 32'd0);
    if (eng != 0) begin
      check_eq("div_A", sa_d, a);
      check_eq("div_B", sb_d, b);
      check_eq("mult_A", sa_m, a);
      check_eq("mult_B", sb_m, b);
    end
    last_r = r; last_x = x;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0; ctrl_MULT = 1'b0;
      check_eq("idle_rdy", 32'(data_resultRDY), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("hold_result", data_result, last_r);
      check_eq("hold_exc", 32'(data_exception), 32'(last_x));
    end
  endtask

  initial begin
    int nrdy, nbusy, kind, lat, spur, drop, gap;
    bit d, m, ex;
    logic [31:0] a, b;
    reset = 1'b1; ctrl_DIV = 1'b0; ctrl_MULT = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    div_out = 32'd0; div_exp = 1'b0; mult_out = 32'd0; mult_exp = 1'b0;
    div_ready = 1'b0; mult_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_result", data_result, 32'd0);
    check_eq("rst_exc", 32'(data_exception), 32'd0);
    check_eq("rst_rdy", 32'(data_resultRDY), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_starts", 32'({div_start, mult_start}), 32'd0);
    check_eq("rst_opA", div_A, 32'd0);
    reset = 1'b0;
    idle(1);

    run_op(1'b1, 1'b0, 32'd100, 32'd7, 31, 1'b0, 0, 0);
    idle(2);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 10, 1'b0, 0, 0);
    idle(1);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 0, 0);
    idle(2);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd6, 16, 1'b0, 5, 0);
    idle(1);
    run_op(1'b1, 1'b0, 32'd77, 32'd5, 1000, 1'b0, 0, 0);
    idle(1);
    run_op(1'b1, 1'b0, 32'd1000, 32'd3, MAXC - 1, 1'b0, 0, 0);
    idle(1);
    run_op(1'b0, 1'b1, 32'd9, 32'd9, 0, 1'b1, 0, 0);
    run_op(1'b1, 1'b0, 32'd1000, 32'd3, 20, 1'b0, 0, 5);
    idle(1);

    // Reset 10 cycles into a divide, then a stray ready after release.
    eng_lat = 1000;
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_result", data_result, 32'd0);
    check_eq("mid_rst_exc", 32'(data_exception), 32'd0);
    check_eq("mid_rst_rdy", 32'(data_resultRDY), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_opA", div_A, 32'd0);
    reset = 1'b0;
    spur_div_at = cyc + 2;
    nrdy = 0; nbusy = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY) nrdy++;
      if (busy) nbusy++;
    end
    check_eq("post_rst_rdy", nrdy, 32'd0);
    check_eq("post_rst_busy", nbusy, 32'd0);
    check_eq("post_rst_result", data_result, 32'd0);
    last_r = 32'd0; last_x = 1'b0;

    run_op(1'b0, 1'b1, 32'd12, 32'd11, 10, 1'b0, 0, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 5, 1'b0, 0, 0);
    run_op(1'b1, 1'b1, 32'd4, 32'd2, 5, 1'b0, 0, 0);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 6);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 1) == 0) b = $urandom_range(1, 50);
      lat = $urandom_range(0, 45);
      ex = 1'($urandom_range(0, 1));
      spur = $urandom_range(0, 50);
      drop = $urandom_range(0, 50);
      case (kind)
        0, 1: begin
          d = 1'b1; m = 1'b0;
          if (b == 32'd0) b = 32'd1;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
        end
        2, 6: begin d = 1'b0; m = 1'b1; end
        3: begin d = 1'b1; m = 1'b0; b = 32'd0; end
        4: begin d = 1'b1; m = 1'b0; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: begin d = 1'b1; m = 1'b1; end
      endcase
      run_op(d, m, a, b, lat, ex, spur, drop);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
